// File: rtl/branch_unit_if.sv
// rtl/branch_unit_if.sv - request, shared-ALU and response signal bundle for branch_unit
//
// Purpose: groups the branch unit's request handshake, shared-ALU port and
// response handshake into one interface.
// Modports:
//   slave  - the branch unit: consumes requests and ALU returns, drives
//            req_ready, the ALU operands/control and the response payload.
//   master - the surrounding pipeline/ALU: drives requests, ALU returns and
//            resp_ready, observes everything else.
// Signals:
//   req_valid/req_ready      request handshake
//   funct3                   RV32 branch type
//   rs1, rs2, pc, imm        operands, branch PC, sign-extended offset
//   alu_a, alu_b, alu_ctrl   drive to the shared ALU (0 ADD, 1 SUB, 4 CMP)
//   alu_result, alu_flag     ALU return (bit0 zero, bit1 sign, bit2 cmp-equal)
//   resp_valid/resp_ready    response handshake
//   taken, target, illegal   response payload

interface branch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [2:0]  alu_flag;
  logic        resp_valid;
  logic        resp_ready;
  logic        taken;
  logic [31:0] target;
  logic        illegal;

  modport slave (
    input  req_valid, funct3, rs1, rs2, pc, imm, alu_result, alu_flag, resp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl, resp_valid, taken, target, illegal
  );

  modport master (
    output req_valid, funct3, rs1, rs2, pc, imm, alu_result, alu_flag, resp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl, resp_valid, taken, target, illegal
  );
endinterface

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - RV32 conditional branch resolution using a shared ALU
//
// Purpose: accepts one branch request at a time, evaluates the condition on
// the shared ALU (CMP state), computes the target (TGT state) and presents
// taken/target/illegal until the response handshake.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous assert, active-low reset
//   bu     - branch_unit_if.slave: request, shared-ALU and response signals
// Configuration:
//   BRANCH_UNIT_FAST_TARGET_EN - when defined, the target is formed by a local
//   pc+imm adder during CMP and the TGT state is skipped (2-cycle legal
//   latency). Undefined (default), the shared ALU computes the target in TGT
//   and the block contains no 32-bit adder of its own.

module branch_unit (
  input  logic         clk,
  input  logic         rst_n,
  branch_unit_if.slave bu
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] TGT  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_CMP = 3'd4;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  logic [1:0]  state_q,      state_d;
  logic [31:0] rs1_q,        rs1_d;
  logic [31:0] rs2_q,        rs2_d;
  logic [31:0] pc_q,         pc_d;
  logic [31:0] imm_q,        imm_d;
  logic [2:0]  funct3_q,     funct3_d;
  logic        taken_q,      taken_d;
  logic [31:0] target_q,     target_d;
  logic        illegal_q,    illegal_d;
  logic        resp_valid_q, resp_valid_d;
`ifndef BRANCH_UNIT_FAST_TARGET_EN
  logic [31:0] diff_q,       diff_d;
  logic        eq_q,         eq_d;
`endif

  // Zero and sign flags are not needed: equality comes from the CMP flag and
  // the sign of the difference is read straight from the result word.
  logic unused_flags;
  assign unused_flags = ^bu.alu_flag[1:0];

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // When the operand signs differ the subtraction can overflow, so the
  // comparison is decided by the operand MSBs instead of the difference.
  function automatic logic branch_taken(input logic [2:0]  f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] diff,
                                        input logic        eq);
    logic lt;
    logic ltu;
    logic res;
    lt  = (a[31] ^ b[31]) ? a[31] : diff[31];
    ltu = (a[31] ^ b[31]) ? b[31] : diff[31];
    case (f3)
      F3_BEQ:  res = eq;
      F3_BNE:  res = ~eq;
      F3_BLT:  res = lt;
      F3_BGE:  res = ~lt;
      F3_BLTU: res = ltu;
      F3_BGEU: res = ~ltu;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    funct3_d     = funct3_q;
    taken_d      = taken_q;
    target_d     = target_q;
    illegal_d    = illegal_q;
    resp_valid_d = resp_valid_q;
`ifndef BRANCH_UNIT_FAST_TARGET_EN
    diff_d       = diff_q;
    eq_d         = eq_q;
`endif
    bu.alu_a     = 32'd0;
    bu.alu_b     = 32'd0;
    bu.alu_ctrl  = ALU_ADD;

    case (state_q)
      IDLE: begin
        if (bu.req_valid) begin
          rs1_d    = bu.rs1;
          rs2_d    = bu.rs2;
          pc_d     = bu.pc;
          imm_d    = bu.imm;
          funct3_d = bu.funct3;
          if (is_illegal(bu.funct3)) begin
            state_d      = RESP;
            taken_d      = 1'b0;
            target_d     = 32'd0;
            illegal_d    = 1'b1;
            resp_valid_d = 1'b1;
          end else begin
            state_d = CMP;
          end
        end
      end

      CMP: begin
        bu.alu_a    = rs1_q;
        bu.alu_b    = rs2_q;
        bu.alu_ctrl = ((funct3_q == F3_BEQ) || (funct3_q == F3_BNE)) ? ALU_CMP : ALU_SUB;
`ifdef BRANCH_UNIT_FAST_TARGET_EN
        taken_d      = branch_taken(funct3_q, rs1_q, rs2_q, bu.alu_result, bu.alu_flag[2]);
        target_d     = pc_q + imm_q;
        illegal_d    = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
`else
        diff_d  = bu.alu_result;
        eq_d    = bu.alu_flag[2];
        state_d = TGT;
`endif
      end

`ifndef BRANCH_UNIT_FAST_TARGET_EN
      TGT: begin
        bu.alu_a     = pc_q;
        bu.alu_b     = imm_q;
        bu.alu_ctrl  = ALU_ADD;
        taken_d      = branch_taken(funct3_q, rs1_q, rs2_q, diff_q, eq_q);
        target_d     = bu.alu_result;
        illegal_d    = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
`endif

      RESP: begin
        // Payload is deliberately kept after the handshake; only valid drops.
        if (bu.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rs1_q        <= 32'd0;
      rs2_q        <= 32'd0;
      pc_q         <= 32'd0;
      imm_q        <= 32'd0;
      funct3_q     <= 3'd0;
      taken_q      <= 1'b0;
      target_q     <= 32'd0;
      illegal_q    <= 1'b0;
      resp_valid_q <= 1'b0;
`ifndef BRANCH_UNIT_FAST_TARGET_EN
      diff_q       <= 32'd0;
      eq_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      funct3_q     <= funct3_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
      illegal_q    <= illegal_d;
      resp_valid_q <= resp_valid_d;
`ifndef BRANCH_UNIT_FAST_TARGET_EN
      diff_q       <= diff_d;
      eq_q         <= eq_d;
`endif
    end
  end

  assign bu.req_ready  = (state_q == IDLE);
  assign bu.resp_valid = resp_valid_q;
  assign bu.taken      = taken_q;
  assign bu.target     = target_q;
  assign bu.illegal    = illegal_q;

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: req_valid  input  1 / req_ready  output  1  request handshake.
REQ-004 SHALL have ports: funct3  input  3  RV32 branch type (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
REQ-005 SHALL have ports: rs1, rs2, pc, imm  input  32 each  operands, branch PC, sign-extended offset.
REQ-006 SHALL have ports: alu_a, alu_b  output  32 / alu_ctrl  output  3  drive to the shared ALU (0 ADD, 1 SUB, 4 CMP).
REQ-007 SHALL have ports: alu_result  input  32 / alu_flag  input  3  ALU return (bit0 zero, bit1 sign, bit2 cmp-equal).
REQ-008 SHALL have ports: resp_valid  output  1 / resp_ready  input  1  response handshake.
REQ-009 SHALL have ports: taken  output  1 / target  output  32 / illegal  output  1  response payload.

Function
REQ-010 FSM states SHALL be IDLE, CMP, TGT, RESP; req_ready=1 only in IDLE.
REQ-011 Request SHALL be accepted on an edge with req_valid&req_ready; rs1, rs2, pc, imm, funct3 captured in internal registers.
REQ-012 After acceptance with legal funct3 the FSM SHALL go IDLE->CMP->TGT->RESP, one cycle each in CMP and TGT.
REQ-013 In CMP: alu_a=rs1, alu_b=rs2, alu_ctrl=CMP for BEQ/BNE, SUB otherwise; alu_result and alu_flag captured at end of cycle.
REQ-014 BEQ taken = alu_flag[2]; BNE taken = ~alu_flag[2].
REQ-015 Signed less-than SHALL be lt = (rs1[31]^rs2[31]) ? rs1[31] : diff[31], diff=captured alu_result; BLT=lt, BGE=~lt.
REQ-016 Unsigned less-than SHALL be ltu = (rs1[31]^rs2[31]) ? rs2[31] : diff[31]; BLTU=ltu, BGEU=~ltu.
REQ-017 In TGT: alu_a=pc, alu_b=imm, alu_ctrl=ADD; target = alu_result captured, 32-bit wrap-around, no overflow indication.
REQ-018 Funct3 010 or 011 SHALL go IDLE->RESP directly with illegal=1, taken=0, target=0.
REQ-019 In RESP resp_valid=1; taken/target/illegal held stable until resp_valid&resp_ready, then next state IDLE.
REQ-020 resp_valid SHALL first assert 3 cycles after the accepting edge (legal), 1 cycle (illegal).
REQ-021 In IDLE and RESP alu_a=alu_b=0, alu_ctrl=0.
REQ-022 A new request SHALL not be accepted in the cycle the response handshakes; earliest acceptance is the following edge.
REQ-023 taken and target SHALL be updated only on state transitions into RESP; they are not cleared on response handshake.

Reset
REQ-024 rst_n low SHALL immediately force IDLE and clear taken, target, illegal, resp_valid, alu_a, alu_b, alu_ctrl, and all captured registers to 0.
REQ-025 Reset asserted mid-operation SHALL drop the in-flight request with no response; req_ready=1 on first edge after deassertion.

Configuration
REQ-026 With BRANCH_UNIT_FAST_TARGET_EN defined, target SHALL be pc+imm from an internal adder computed during CMP, TGT state omitted, legal latency 2 cycles.
REQ-027 Without BRANCH_UNIT_FAST_TARGET_EN, the ALU SHALL compute target in TGT and no internal 32-bit adder SHALL exist.

Verification
REQ-028 BEQ rs1=5 rs2=5 pc=0x100 imm=0x20 -> taken=1, target=0x120, resp_valid 3 cycles after acceptance (2 with macro).
REQ-029 BLT rs1=0xFFFFFFFF rs2=1 -> taken=1; same operands BLTU -> taken=0.
REQ-030 BGE rs1=0x80000000 rs2=0x7FFFFFFF -> taken=0; BNE pc=0xFFFFFFF0 imm=0x20 -> target=0x00000010 (wrap-around).
REQ-031 funct3=010 -> illegal=1, taken=0, target=0, resp_valid 1 cycle after acceptance.
REQ-032 resp_ready held low 5 cycles -> resp_valid, taken, target stable, req_ready=0 throughout; accepted next request only after handshake.
REQ-033 rst_n pulsed low during TGT -> no resp_valid, all outputs 0, next request completes normally.
